// File: rtl/pmcc_seq_pkg.sv
// Shared constants for the pixel-matrix-control coprocessor program sequencer.
// Holds the FSM state encodings and the default parameter values used by
// pmcc_sequencer and pmcc_loop_stack.
package pmcc_seq_pkg;

  localparam int unsigned PcWDefault        = 8;
  localparam int unsigned SizeWDefault      = 2;
  localparam int unsigned LoopDepthDefault  = 4;
  localparam int unsigned CntWDefault       = 10;
  localparam int unsigned TrigNDefault      = 4;

  // Sequencer FSM states
  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StWait = 2'd2;
  localparam logic [1:0] StHalt = 2'd3;

endpackage

// File: rtl/pmcc_loop_stack.sv
// Hardware loop stack: LOOP_DEPTH entries of {start address, iteration count}.
// Ports:
//   clk_i         clock
//   clear_i       synchronous clear (empties the stack)
//   push_i        push {push_start_i, push_cnt_i}; ignored when full
//   pop_i         drop top entry; ignored when empty
//   dec_i         decrement top count; ignored when empty
//   top_start_o   start address of innermost loop
//   top_cnt_o     remaining iterations of innermost loop
//   level_o       number of occupied entries
//   full_o        level_o == LOOP_DEPTH
//   empty_o       level_o == 0
module pmcc_loop_stack
  import pmcc_seq_pkg::*;
#(
  parameter int unsigned PC_W       = PcWDefault,
  parameter int unsigned CNT_W      = CntWDefault,
  parameter int unsigned LOOP_DEPTH = LoopDepthDefault
) (
  input  logic                              clk_i,
  input  logic                              clear_i,
  input  logic                              push_i,
  input  logic                              pop_i,
  input  logic                              dec_i,
  input  logic [PC_W-1:0]                   push_start_i,
  input  logic [CNT_W-1:0]                  push_cnt_i,
  output logic [PC_W-1:0]                   top_start_o,
  output logic [CNT_W-1:0]                  top_cnt_o,
  output logic [$clog2(LOOP_DEPTH+1)-1:0]   level_o,
  output logic                              full_o,
  output logic                              empty_o
);

  localparam int unsigned LvlW = $clog2(LOOP_DEPTH + 1);
  localparam int unsigned IdxW = (LOOP_DEPTH > 1) ? $clog2(LOOP_DEPTH) : 1;

  logic [PC_W-1:0]  start_q [LOOP_DEPTH];
  logic [CNT_W-1:0] cnt_q   [LOOP_DEPTH];
  logic [LvlW-1:0]  level_q, level_d, top_lvl;
  logic [IdxW-1:0]  top_idx, push_idx;
  logic             do_push, do_pop, do_dec;

  assign full_o  = (level_q == LvlW'(LOOP_DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;

  always_comb begin
    top_lvl  = level_q - LvlW'(1);
    top_idx  = top_lvl[IdxW-1:0];
    push_idx = level_q[IdxW-1:0];
    // One operation per cycle; push has precedence, then pop, then decrement.
    do_push  = push_i & ~full_o;
    do_pop   = pop_i & ~push_i & ~empty_o;
    do_dec   = dec_i & ~push_i & ~pop_i & ~empty_o;
    level_d  = level_q;
    if (do_push) begin
      level_d = level_q + LvlW'(1);
    end else if (do_pop) begin
      level_d = level_q - LvlW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      level_q <= '0;
      for (int i = 0; i < int'(LOOP_DEPTH); i++) begin
        start_q[i] <= '0;
        cnt_q[i]   <= '0;
      end
    end else begin
      level_q <= level_d;
      if (do_push) begin
        start_q[push_idx] <= push_start_i;
        cnt_q[push_idx]   <= push_cnt_i;
      end
      if (do_dec) begin
        cnt_q[top_idx] <= cnt_q[top_idx] - CNT_W'(1);
      end
    end
  end

  assign top_start_o = start_q[top_idx];
  assign top_cnt_o   = cnt_q[top_idx];

endmodule

// File: rtl/pmcc_sequencer.sv
// Program sequencer for the pixel-matrix-control coprocessor. Produces the
// instruction-memory fetch address (pc_if_o, combinational) and tracks the
// address of the instruction in decode (pc_id_o). Handles sequential advance,
// jumps, nested hardware loops, trigger waits and halt.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   restart_i           soft restart: like reset but error flags are kept
//   start_i             IDLE -> RUN
//   enable_i            0 freezes all state, pc_if_o = pc_id_o (0 in IDLE)
//   instr_size_i        extra words occupied by the decoded instruction
//   jump_i/jump_dst_i   jump and its target
//   loop_push_i/loop_cnt_i  open loop with given iteration count
//   loop_end_i          close innermost loop
//   wait_en_i/wait_sel_i    wait for any trigger in mask
//   trigger_i           level-sensitive trigger inputs
//   halt_i              stop program
//   pc_if_o, pc_id_o    fetch and decode addresses
//   busy_o, waiting_o, halted_o  state flags
//   loop_level_o        loop stack occupancy
//   err_overflow_o, err_underflow_o  sticky loop-stack error flags
module pmcc_sequencer
  import pmcc_seq_pkg::*;
#(
  parameter int unsigned PC_W       = PcWDefault,
  parameter int unsigned SIZE_W     = SizeWDefault,
  parameter int unsigned LOOP_DEPTH = LoopDepthDefault,
  parameter int unsigned CNT_W      = CntWDefault,
  parameter int unsigned TRIG_N     = TrigNDefault
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              restart_i,
  input  logic                              start_i,
  input  logic                              enable_i,
  input  logic [SIZE_W-1:0]                 instr_size_i,
  input  logic                              jump_i,
  input  logic [PC_W-1:0]                   jump_dst_i,
  input  logic                              loop_push_i,
  input  logic [CNT_W-1:0]                  loop_cnt_i,
  input  logic                              loop_end_i,
  input  logic                              wait_en_i,
  input  logic [TRIG_N-1:0]                 wait_sel_i,
  input  logic [TRIG_N-1:0]                 trigger_i,
  input  logic                              halt_i,
  output logic [PC_W-1:0]                   pc_if_o,
  output logic [PC_W-1:0]                   pc_id_o,
  output logic                              busy_o,
  output logic                              waiting_o,
  output logic                              halted_o,
  output logic [$clog2(LOOP_DEPTH+1)-1:0]   loop_level_o,
  output logic                              err_overflow_o,
  output logic                              err_underflow_o
);

  logic [1:0]        state_q, state_d;
  logic [PC_W-1:0]   pc_id_q, pc_mux, seq;
  logic [TRIG_N-1:0] wait_sel_q, wait_sel_d;
  logic              err_ov_q, err_ov_d, err_un_q, err_un_d;
  logic              wait_pass, wait_done;
  logic              stk_clear, stk_push, stk_pop, stk_dec, stk_full, stk_empty;
  logic [PC_W-1:0]   stk_top_start;
  logic [CNT_W-1:0]  stk_top_cnt;

  // Address of the next instruction; wraps modulo 2^PC_W.
  assign seq = pc_id_q + PC_W'(instr_size_i) + PC_W'(1);

  // An empty mask never stalls.
  assign wait_pass = ((trigger_i & wait_sel_i) != '0) || (wait_sel_i == '0);
  assign wait_done = (trigger_i & wait_sel_q) != '0;

  assign stk_clear = rst_i | restart_i;

  pmcc_loop_stack #(
    .PC_W       (PC_W),
    .CNT_W      (CNT_W),
    .LOOP_DEPTH (LOOP_DEPTH)
  ) u_loop_stack (
    .clk_i        (clk_i),
    .clear_i      (stk_clear),
    .push_i       (stk_push),
    .pop_i        (stk_pop),
    .dec_i        (stk_dec),
    .push_start_i (seq),
    .push_cnt_i   (loop_cnt_i),
    .top_start_o  (stk_top_start),
    .top_cnt_o    (stk_top_cnt),
    .level_o      (loop_level_o),
    .full_o       (stk_full),
    .empty_o      (stk_empty)
  );

  always_comb begin
    state_d    = state_q;
    wait_sel_d = wait_sel_q;
    err_ov_d   = err_ov_q;
    err_un_d   = err_un_q;
    pc_mux     = pc_id_q;
    stk_push   = 1'b0;
    stk_pop    = 1'b0;
    stk_dec    = 1'b0;
    case (state_q)
      StIdle: begin
        pc_mux = '0;
        if (enable_i && start_i) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (enable_i) begin
          if (halt_i) begin
            state_d = StHalt;
          end else if (wait_en_i) begin
            if (wait_pass) begin
              pc_mux = seq;
            end else begin
              wait_sel_d = wait_sel_i;
              state_d    = StWait;
            end
          end else if (jump_i) begin
            pc_mux = jump_dst_i;
          end else if (loop_end_i) begin
            if (stk_empty) begin
              err_un_d = 1'b1;
              pc_mux   = seq;
            end else if (stk_top_cnt > CNT_W'(1)) begin
              stk_dec = 1'b1;
              pc_mux  = stk_top_start;
            end else begin
              // Count of 0 or 1 means this was the last pass.
              stk_pop = 1'b1;
              pc_mux  = seq;
            end
          end else begin
            pc_mux = seq;
            if (loop_push_i) begin
              if (stk_full) begin
                err_ov_d = 1'b1;
              end else begin
                stk_push = 1'b1;
              end
            end
          end
        end
      end
      StWait: begin
        // instr_size_i still refers to the waiting instruction.
        if (enable_i && wait_done) begin
          pc_mux  = seq;
          state_d = StRun;
        end
      end
      default: begin
        pc_mux = pc_id_q;
      end
    endcase
  end

  assign pc_if_o = stk_clear ? '0 : pc_mux;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      pc_id_q    <= '0;
      wait_sel_q <= '0;
      err_ov_q   <= 1'b0;
      err_un_q   <= 1'b0;
    end else if (restart_i) begin
      state_q    <= StIdle;
      pc_id_q    <= '0;
      wait_sel_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_id_q    <= pc_if_o;
      wait_sel_q <= wait_sel_d;
      err_ov_q   <= err_ov_d;
      err_un_q   <= err_un_d;
    end
  end

  assign pc_id_o         = pc_id_q;
  assign busy_o          = (state_q == StRun) || (state_q == StWait);
  assign waiting_o       = (state_q == StWait);
  assign halted_o        = (state_q == StHalt);
  assign err_overflow_o  = err_ov_q;
  assign err_underflow_o = err_un_q;

endmodule

// File: tb/tb_pmcc_sequencer.sv
// Bench for pmcc_sequencer: directed scenarios plus random decode traffic,
// expected outputs from a queue-based reference model, checked by a monitor.
module tb_pmcc_sequencer;

  localparam int PC_W       = 8;
  localparam int SIZE_W     = 2;
  localparam int LOOP_DEPTH = 4;
  localparam int CNT_W      = 10;
  localparam int TRIG_N     = 4;
  localparam int LVL_W      = $clog2(LOOP_DEPTH + 1);

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_WAIT = 2;
  localparam int M_HALT = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, restart, start, enable, jump, loop_push, loop_end, wait_en, halt;
  logic [SIZE_W-1:0] instr_size;
  logic [PC_W-1:0]   jump_dst;
  logic [CNT_W-1:0]  loop_cnt;
  logic [TRIG_N-1:0] wait_sel, trigger;
  logic [PC_W-1:0]   pc_if, pc_id;
  logic              busy, waiting, halted, err_ov, err_un;
  logic [LVL_W-1:0]  loop_level;

  pmcc_sequencer #(
    .PC_W(PC_W), .SIZE_W(SIZE_W), .LOOP_DEPTH(LOOP_DEPTH), .CNT_W(CNT_W), .TRIG_N(TRIG_N)
  ) dut (
    .clk_i(clk), .rst_i(rst), .restart_i(restart), .start_i(start), .enable_i(enable),
    .instr_size_i(instr_size), .jump_i(jump), .jump_dst_i(jump_dst),
    .loop_push_i(loop_push), .loop_cnt_i(loop_cnt), .loop_end_i(loop_end),
    .wait_en_i(wait_en), .wait_sel_i(wait_sel), .trigger_i(trigger), .halt_i(halt),
    .pc_if_o(pc_if), .pc_id_o(pc_id), .busy_o(busy), .waiting_o(waiting),
    .halted_o(halted), .loop_level_o(loop_level),
    .err_overflow_o(err_ov), .err_underflow_o(err_un)
  );

  typedef struct {
    bit chk_pc;
    int pc_if, pc_id, busy, waiting, halted, level, ov, un;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state
  int m_state = M_IDLE;
  int m_pc    = 0;
  int m_sel   = 0;
  int m_ov    = 0;
  int m_un    = 0;
  int stk_start[$];
  int stk_cnt[$];

  task automatic check(input string name, input logic [31:0] act, input int expv);
    n_checks++;
    if (act !== 32'(expv)) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Computes what the DUT should show this cycle, then advances the model.
  task automatic model_step();
    exp_t e;
    int   seq, pcif;
    e.chk_pc  = !(rst || restart);
    e.pc_id   = m_pc;
    e.busy    = (m_state == M_RUN || m_state == M_WAIT) ? 1 : 0;
    e.waiting = (m_state == M_WAIT) ? 1 : 0;
    e.halted  = (m_state == M_HALT) ? 1 : 0;
    e.level   = stk_cnt.size();
    e.ov      = m_ov;
    e.un      = m_un;
    seq  = (m_pc + int'(instr_size) + 1) % (1 << PC_W);
    pcif = m_pc;
    if (rst || restart) begin
      m_state = M_IDLE;
      m_pc    = 0;
      m_sel   = 0;
      stk_start.delete();
      stk_cnt.delete();
      if (rst) begin
        m_ov = 0;
        m_un = 0;
      end
      pcif = 0;
    end else begin
      if (!enable) begin
        pcif = (m_state == M_IDLE) ? 0 : m_pc;
      end else if (m_state == M_IDLE) begin
        pcif = 0;
        if (start) m_state = M_RUN;
      end else if (m_state == M_RUN) begin
        if (halt) begin
          m_state = M_HALT;
        end else if (wait_en) begin
          if ((int'(trigger) & int'(wait_sel)) != 0 || wait_sel == 0) pcif = seq;
          else begin
            m_sel   = int'(wait_sel);
            m_state = M_WAIT;
          end
        end else if (jump) begin
          pcif = int'(jump_dst);
        end else if (loop_end) begin
          if (stk_cnt.size() == 0) begin
            m_un = 1;
            pcif = seq;
          end else if (stk_cnt[stk_cnt.size()-1] > 1) begin
            stk_cnt[stk_cnt.size()-1] -= 1;
            pcif = stk_start[stk_start.size()-1];
          end else begin
            void'(stk_cnt.pop_back());
            void'(stk_start.pop_back());
            pcif = seq;
          end
        end else begin
          pcif = seq;
          if (loop_push) begin
            if (stk_cnt.size() == LOOP_DEPTH) m_ov = 1;
            else begin
              stk_start.push_back(seq);
              stk_cnt.push_back(loop_cnt == 0 ? 1 : int'(loop_cnt));
            end
          end
        end
      end else if (m_state == M_WAIT) begin
        if ((int'(trigger) & m_sel) != 0) begin
          pcif    = seq;
          m_state = M_RUN;
        end
      end
      m_pc = pcif;
    end
    e.pc_if = pcif;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e.chk_pc) check("pc_if", 32'(pc_if), e.pc_if);
      check("pc_id", 32'(pc_id), e.pc_id);
      check("busy", 32'(busy), e.busy);
      check("waiting", 32'(waiting), e.waiting);
      check("halted", 32'(halted), e.halted);
      check("loop_level", 32'(loop_level), e.level);
      check("err_overflow", 32'(err_ov), e.ov);
      check("err_underflow", 32'(err_un), e.un);
    end
  end

  task automatic clr();
    rst = 0; restart = 0; start = 0; enable = 1; instr_size = '0; jump = 0; jump_dst = '0;
    loop_push = 0; loop_cnt = '0; loop_end = 0; wait_en = 0; wait_sel = '0; trigger = '0;
    halt = 0;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic boot();
    clr(); restart = 1; tick();
    clr(); start = 1; tick();
    clr();
  endtask

  task automatic adv_to(input int pc);
    for (int k = 0; k < 300 && m_pc != pc; k++) tick();
  endtask

  initial begin
    clr();
    rst = 1;
    @(posedge clk);
    #1;
    // Sequential advance with mixed sizes
    tick();
    clr(); start = 1; tick();
    clr();
    instr_size = 2'd0; tick();
    instr_size = 2'd1; tick();
    instr_size = 2'd2; tick();
    instr_size = 2'd0; tick();
    // Loop of 3 iterations over 3..5
    boot(); adv_to(2);
    loop_push = 1; loop_cnt = 10'd3; tick();
    clr();
    for (int k = 0; k < 20 && m_pc != 6; k++) begin
      loop_end = (m_pc == 5);
      tick();
    end
    clr(); tick();
    // Wait stall then release, then wait with trigger preset
    boot(); adv_to(4);
    wait_en = 1; wait_sel = 4'b0010; trigger = 4'b0001; tick();
    clr(); trigger = 4'b0001;
    repeat (5) tick();
    trigger = 4'b0010; tick();
    clr(); tick();
    wait_en = 1; wait_sel = 4'b0010; trigger = 4'b0010; tick();
    clr(); tick();
    // Overflow, then pop all plus one underflow, flags held over restart
    boot();
    for (int k = 0; k < 5; k++) begin
      loop_push = 1; loop_cnt = 10'd1; tick();
    end
    clr();
    for (int k = 0; k < 5; k++) begin
      loop_end = 1; tick();
    end
    clr(); tick();
    restart = 1; tick();
    clr(); tick(); tick();
    // Jump near top, wrap, halt, start ignored, restart
    boot();
    jump = 1; jump_dst = 8'hFE; tick();
    clr(); instr_size = 2'd2; tick();
    clr(); tick();
    halt = 1; tick();
    clr();
    for (int k = 0; k < 3; k++) begin
      start = 1; tick();
    end
    clr(); restart = 1; tick();
    clr(); tick();
    // Restart while waiting with two open loops; enable freeze mid-run
    boot();
    loop_push = 1; loop_cnt = 10'd3; tick(); tick();
    clr(); wait_en = 1; wait_sel = 4'b0100; tick();
    clr(); tick();
    restart = 1; tick();
    clr(); tick();
    start = 1; tick();
    clr(); tick(); tick();
    for (int k = 0; k < 4; k++) begin
      enable = 0; instr_size = SIZE_W'($urandom_range(0, 3)); jump = 1;
      jump_dst = PC_W'($urandom_range(0, 255)); trigger = TRIG_N'($urandom_range(0, 15));
      tick();
    end
    clr(); tick(); tick();
    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      rst        = ($urandom_range(0, 199) == 0);
      restart    = ($urandom_range(0, 49) == 0);
      start      = ($urandom_range(0, 5) == 0);
      enable     = ($urandom_range(0, 7) != 0);
      instr_size = SIZE_W'($urandom_range(0, 3));
      jump       = ($urandom_range(0, 9) == 0);
      jump_dst   = PC_W'($urandom_range(0, 255));
      loop_push  = ($urandom_range(0, 3) == 0);
      loop_cnt   = CNT_W'($urandom_range(0, 3));
      loop_end   = ($urandom_range(0, 4) == 0);
      wait_en    = ($urandom_range(0, 9) == 0);
      wait_sel   = TRIG_N'($urandom_range(0, 15));
      trigger    = TRIG_N'($urandom_range(0, 15));
      halt       = ($urandom_range(0, 79) == 0);
      tick();
    end
    clr();
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
